// File: rtl/wb_spi_reg_arbiter.sv
// Round-robin arbiter giving Wishbone and SPI masters single-word access to a
// bank of free-running 32-bit counters, with a registered one-cycle ack per grant.
module wb_spi_reg_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cnt_en_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_adr_i,
  input  logic [31:0]       spi_data_i,
  output logic [31:0]       spi_data_o,
  output logic              spi_ack_o,
  output logic [1:0]        owner_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WB_ACK  = 2'b01,
    SPI_ACK = 2'b10
  } state_t;

  // Masking keeps indices in range when NUM_REGS is 1 (ADDR_W is then padded to 1).
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic              last_win_spi_reg, last_win_spi_next;
  logic [31:0]       regs_reg  [NUM_REGS];
  logic [31:0]       regs_next [NUM_REGS];
  logic [31:0]       wb_dat_reg, spi_dat_reg;
  logic              wb_req, wb_grant, spi_grant;
  logic [ADDR_W-1:0] wb_idx, spi_idx;
  logic [31:0]       wb_lane_mask;
  logic              unused_adr_bits;

  assign wb_req          = wb_cyc_i & wb_stb_i;
  assign wb_idx          = wb_adr_i[ADDR_W+1:2] & IDX_MASK;
  assign spi_idx         = spi_adr_i & IDX_MASK;
  assign wb_lane_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_adr_bits = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  // Ties go to the side that did not win last; the ack state always returns to IDLE.
  always_comb begin
    state_next        = state_reg;
    last_win_spi_next = last_win_spi_reg;
    wb_grant          = 1'b0;
    spi_grant         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_req && (!spi_req_i || last_win_spi_reg)) begin
          wb_grant          = 1'b1;
          state_next        = WB_ACK;
          last_win_spi_next = 1'b0;
        end else if (spi_req_i) begin
          spi_grant         = 1'b1;
          state_next        = SPI_ACK;
          last_win_spi_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A written register skips its increment for that cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic wb_hit, spi_hit;
      assign wb_hit  = wb_grant & wb_we_i & (wb_idx == ADDR_W'(gi));
      assign spi_hit = spi_grant & spi_we_i & (spi_idx == ADDR_W'(gi));
      assign regs_next[gi] =
          wb_hit   ? ((regs_reg[gi] & ~wb_lane_mask) | (wb_dat_i & wb_lane_mask)) :
          spi_hit  ? spi_data_i :
          cnt_en_i ? regs_reg[gi] + 32'd1 :
                     regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      last_win_spi_reg <= 1'b1;
      wb_dat_reg       <= '0;
      spi_dat_reg      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      state_reg        <= state_next;
      last_win_spi_reg <= last_win_spi_next;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= regs_next[i];
      // Read data captures the pre-update value of the grant cycle.
      if (wb_grant)  wb_dat_reg  <= regs_reg[wb_idx];
      if (spi_grant) spi_dat_reg <= regs_reg[spi_idx];
    end
  end

  assign wb_dat_o   = wb_dat_reg;
  assign spi_data_o = spi_dat_reg;
  assign wb_ack_o   = (state_reg == WB_ACK);
  assign spi_ack_o  = (state_reg == SPI_ACK);
  assign owner_o    = {state_reg == SPI_ACK, state_reg == WB_ACK};

endmodule

// File: tb/tb_wb_spi_reg_arbiter.sv
// Scoreboard bench for wb_spi_reg_arbiter: a cycle-level reference model queues
// expected read data and ack cycles; a negedge monitor compares every ack and owner.
module tb_wb_spi_reg_arbiter;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cnt_en_i = 1'b0;
  logic              wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]       wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]        wb_sel_i = '0;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              spi_req_i = 1'b0, spi_we_i = 1'b0;
  logic [ADDR_W-1:0] spi_adr_i = '0;
  logic [31:0]       spi_data_i = '0;
  logic [31:0]       spi_data_o;
  logic              spi_ack_o;
  logic [1:0]        owner_o;

  always #5 clk_i = ~clk_i;

  wb_spi_reg_arbiter #(.NUM_REGS(NUM_REGS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cnt_en_i(cnt_en_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .spi_req_i(spi_req_i), .spi_we_i(spi_we_i), .spi_adr_i(spi_adr_i),
    .spi_data_i(spi_data_i), .spi_data_o(spi_data_o), .spi_ack_o(spi_ack_o),
    .owner_o(owner_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t        wb_q[$];
  exp_t        spi_q[$];
  logic [31:0] mregs [NUM_REGS];
  bit          m_busy;
  bit          m_last_spi;
  logic [1:0]  m_owner;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: rules of the arbiter expressed per clock cycle.
  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
    m_busy     = 1'b0;
    m_last_spi = 1'b1;
    m_owner    = 2'b00;
    wb_q.delete();
    spi_q.delete();
  endtask

  task automatic model_step();
    bit          wr;
    int          widx;
    int          idx;
    logic [31:0] wval;
    logic [31:0] mask;
    bit          wbr;
    bit          spr;
    wr   = 1'b0;
    widx = 0;
    wval = '0;
    if (m_busy) begin
      m_busy  = 1'b0;
      m_owner = 2'b00;
    end else begin
      wbr = wb_cyc_i && wb_stb_i;
      spr = spi_req_i;
      if (wbr && (!spr || m_last_spi)) begin
        idx = int'((wb_adr_i >> 2) % 32'(NUM_REGS));
        wb_q.push_back('{mregs[idx], cyc + 1});
        if (wb_we_i) begin
          mask = '0;
          for (int k = 0; k < 4; k++) if (wb_sel_i[k]) mask = mask | (32'hFF << (8 * k));
          wr   = 1'b1;
          widx = idx;
          wval = (mregs[idx] & ~mask) | (wb_dat_i & mask);
        end
        m_last_spi = 1'b0;
        m_busy     = 1'b1;
        m_owner    = 2'b01;
      end else if (spr) begin
        idx = int'(spi_adr_i) % NUM_REGS;
        spi_q.push_back('{mregs[idx], cyc + 1});
        if (spi_we_i) begin
          wr   = 1'b1;
          widx = idx;
          wval = spi_data_i;
        end
        m_last_spi = 1'b1;
        m_busy     = 1'b1;
        m_owner    = 2'b10;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr && i == widx) mregs[i] = wval;
      else if (cnt_en_i)   mregs[i] = mregs[i] + 32'd1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_reset();
      else begin
        model_step();
        cyc++;
      end
    end
  end

  // Monitor: every ack must match the head of its side's queue, in data and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      check32("owner", {30'd0, owner_o}, {30'd0, m_owner});
      if (wb_ack_o) begin
        if (wb_q.size() == 0) check32("wb_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = wb_q.pop_front();
          check32("wb_rdata", wb_dat_o, e.data);
          check_int("wb_ack_cycle", cyc, e.cycle);
        end
      end
      if (spi_ack_o) begin
        if (spi_q.size() == 0) check32("spi_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = spi_q.pop_front();
          check32("spi_rdata", spi_data_o, e.data);
          check_int("spi_ack_cycle", cyc, e.cycle);
        end
      end
    end
  end

  // Drivers: called at posedge+1, hold the request until ack, release at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
    int n;
    n = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    do begin
      @(negedge clk_i);
      n++;
    end while (!wb_ack_o && n < 20);
    if (!wb_ack_o) check32("wb_ack_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic spi_access(input bit we, input logic [ADDR_W-1:0] adr, input logic [31:0] dat);
    int n;
    n = 0;
    spi_req_i = 1'b1; spi_we_i = we; spi_adr_i = adr; spi_data_i = dat;
    do begin
      @(negedge clk_i);
      n++;
    end while (!spi_ack_o && n < 20);
    if (!spi_ack_o) check32("spi_ack_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    spi_req_i = 1'b0;
  endtask

  task automatic wb_rand();
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    else wb_access(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
  endtask

  task automatic spi_rand();
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    else spi_access(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
  endtask

  initial begin
    cnt_en_i = 1'b1;
    #20 rst_ni = 1'b1;
    idle(4);
    // Counters run from reset: reg0 reads 4 in its grant cycle.
    spi_access(1'b0, 2'd0, '0);
    check32("reset_count_read", spi_data_o, 32'h0000_0004);

    cnt_en_i = 1'b0;
    spi_access(1'b1, 2'd1, 32'h1122_3344);
    wb_access(1'b1, 32'h4, 4'b0101, 32'hAABB_CCDD);
    wb_access(1'b0, 32'h4, 4'b1111, '0);
    check32("byte_lane_write", wb_dat_o, 32'h11BB_33DD);
    wb_access(1'b1, 32'h8, 4'b0000, 32'hDEAD_BEEF);

    cnt_en_i = 1'b1;
    spi_access(1'b1, 2'd2, 32'hFFFF_FFFF);
    spi_access(1'b0, 2'd2, '0);
    check32("wrap_after_write", spi_data_o, 32'h0000_0000);

    cnt_en_i = 1'b0;
    wb_access(1'b1, 32'h14, 4'b1111, 32'hCAFE_F00D);
    spi_access(1'b0, 2'd1, '0);
    check32("alias_read", spi_data_o, 32'hCAFE_F00D);

    // Reset asserted during an ack cycle.
    cnt_en_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = '0;
    @(posedge clk_i);
    #3;
    check32("ack_before_reset", {31'd0, wb_ack_o}, 32'd1);
    rst_ni = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    check32("reset_wb_ack", {31'd0, wb_ack_o}, 32'd0);
    check32("reset_owner", {30'd0, owner_o}, 32'd0);
    check32("reset_wb_dat", wb_dat_o, 32'd0);
    check32("reset_spi_dat", spi_data_o, 32'd0);
    cnt_en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1);

    // Continuous contention after reset: WB, SPI, WB, SPI.
    fork
      repeat (2) wb_access(1'b0, 32'h0, 4'hF, '0);
      repeat (2) spi_access(1'b0, 2'd3, '0);
    join

    for (int it = 0; it < 150; it++) begin
      cnt_en_i = 1'($urandom_range(0, 1));
      fork
        wb_rand();
        spi_rand();
      join
    end

    idle(4);
    check_int("wb_queue_drained", wb_q.size(), 0);
    check_int("spi_queue_drained", spi_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_spi_reg_arbiter.md
# wb_spi_reg_arbiter

Shared register-bank controller that arbitrates Wishbone and SPI-side requesters onto a small bank of free-running 32-bit counter registers. Both masters get single-word read/write access through a registered ack handshake. Access is granted round-robin, so neither side starves. The block sits behind the Wishbone slave decode and the SPI command decoder. It replaces the single counter register that both buses previously wrote directly.

## Interface
Parameters:
- NUM_REGS, 4, number of 32-bit registers; power of two, 1..16
- ADDR_W, $clog2(NUM_REGS) (min 1), register index width

Ports:
- clk_i  in  1  single system clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- cnt_en_i  in  1  global count enable; when high, every register not being written increments by 1 per cycle
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  32  byte address; word index = wb_adr_i[ADDR_W+1:2], other bits ignored
- wb_sel_i  in  4  byte lane selects
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  ack, registered, one-cycle pulse
- spi_req_i  in  1  SPI-side request (level, held until ack)
- spi_we_i  in  1  SPI write enable
- spi_adr_i  in  ADDR_W  register index
- spi_data_i  in  32  write data (always full word)
- spi_data_o  out  32  read data, registered
- spi_ack_o  out  1  ack, registered, one-cycle pulse
- owner_o  out  2  current grant: 00 none, 01 WB, 10 SPI

## Operation
- FSM states: IDLE, WB_ACK, SPI_ACK.
- A WB request is wb_cyc_i & wb_stb_i. An SPI request is spi_req_i.
- IDLE, one request pending: grant it.
- IDLE, both requests pending: grant the side opposite last_win.
- IDLE, no request: stay in IDLE.
- Grant in IDLE, edge ending that cycle:
  - Read data latches the addressed register's current value, before the write or increment.
  - Any write commits.
  - last_win updates.
  - State moves to WB_ACK or SPI_ACK.
- WB_ACK / SPI_ACK: the matching ack_o is high for exactly this cycle. The state then returns to IDLE unconditionally, so a request cannot be re-granted in the ack cycle.
- WB write: each byte lane with wb_sel_i[k]=1 takes wb_dat_i[8k+7:8k]. Unselected lanes hold their current value. The addressed register does not increment that cycle.
- wb_sel_i=0000 write: acked, register held (no increment).
- SPI write: the full 32-bit spi_data_i replaces the register, with no increment.
- Reads never modify registers. The addressed register increments normally on a read cycle.
- Increment wraps 0xFFFFFFFF -> 0x00000000.
- Read data outputs hold their last value until the next grant to the same side.
- If the master drops its request during the ack state, the ack still pulses and the write is already committed.

## Timing
- Reset (rst_ni low, asynchronous), effective immediately:
  - all registers 0x00000000
  - wb_dat_o = spi_data_o = 0
  - wb_ack_o = spi_ack_o = 0
  - owner_o = 00
  - state IDLE
  - last_win = SPI, so WB wins the first tie
- A reset asserted during an ack state kills the pulse immediately. After reset, no stale ack is produced.
- Latency: request visible in cycle N (IDLE) -> ack in cycle N+1. Throughput is at most one access per 2 cycles, shared.
- owner_o is 01/10 during WB_ACK/SPI_ACK and 00 in IDLE.
- Contention: the losing side waits exactly 2 cycles (one access by the winner), then is granted in the next IDLE even if the winner re-requests.
- Address aliasing: indices wrap modulo NUM_REGS (upper bits dropped).

## Test plan
- Reset then idle, cnt_en_i=1, 5 cycles -> SPI read of reg 0 returns 0x00000004 (value in its grant cycle). Acks arrive one cycle after the request.
- WB write adr 0x4, sel 0101, dat 0xAABBCCDD, onto reg1=0x11223344 with cnt_en_i=0 -> reg1=0x11BB33DD. wb_ack_o pulses once, in cycle N+1.
- WB and SPI both request from reset, held continuously -> grant order WB, SPI, WB, SPI. Each ack is 2 cycles apart; owner_o alternates 01/10.
- SPI write reg2=0xFFFFFFFF with cnt_en_i=1 -> next-cycle value 0x00000000. Reg2 does not increment on the write cycle itself.
- Assert rst_ni low mid-WB_ACK -> wb_ack_o drops asynchronously, all registers and outputs read 0. The first post-reset tie is won by WB.
- NUM_REGS=4: WB access at adr 0x14 and SPI access at index 1 -> both hit reg1.
